// File: rtl/tx_block_arbiter_if.sv
// Block-producer and TX FIFO signal bundle for tx_block_arbiter.
// master = producers / FIFO side, slave = the arbiter.
// blk_count width follows SEQ_W; keep it equal to the arbiter's SEQ_W.
interface tx_block_arbiter_if #(
  parameter int SEQ_W = 16
);
  logic [127:0]     res_data;
  logic [1:0]       res_mode;
  logic             res_valid;
  logic             res_busy;
  logic [127:0]     q_data;
  logic             q_valid;
  logic             q_busy;
  logic             frame_done;
  logic             FIFO_tx_full;
  logic [31:0]      FIFO_tx_din;
  logic             FIFO_tx_enable;
  logic [SEQ_W-1:0] blk_count;
  logic             overflow;

  modport master (
    output res_data, res_mode, res_valid, q_data, q_valid, frame_done, FIFO_tx_full,
    input  res_busy, q_busy, FIFO_tx_din, FIFO_tx_enable, blk_count, overflow
  );

  modport slave (
    input  res_data, res_mode, res_valid, q_data, q_valid, frame_done, FIFO_tx_full,
    output res_busy, q_busy, FIFO_tx_din, FIFO_tx_enable, blk_count, overflow
  );
endinterface

// File: rtl/tx_block_arbiter.sv
// Round-robin serializer of two 128-bit block slots onto a 32-bit TX FIFO port.
// Latency: block offered in cycle N -> header in N+2, data N+3..N+6 (HDR_EN=1).
// Backpressure: FIFO_tx_full in cycle C suppresses the write in C+1; word and state hold.
module tx_block_arbiter #(
  parameter bit HDR_EN = 1'b1,
  parameter int SEQ_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  tx_block_arbiter_if.slave bus
);

  // state names the word currently (or most recently) placed on the FIFO port
  typedef enum logic [1:0] {IDLE, HDR, DATA, EOF} state_t;

  state_t           state, nxt_state;
  logic [1:0]       idx, nxt_idx;
  logic             gnt, nxt_gnt;
  logic             rr;
  logic             grant, adv, blk_done, eof_done;
  logic             s0_full, s1_full;
  logic [127:0]     s0_data, s1_data;
  logic [1:0]       s0_mode;
  logic [SEQ_W-1:0] seq, blk_cnt;
  logic             ovf, eof_pend;
  logic [31:0]      din, word;
  logic             en;
  logic [15:0]      seq16;
  logic             pick;
  logic [127:0]     cur_data;

  assign seq16    = 16'(seq);
  // both full: take the port the RR pointer names; otherwise the only full one
  assign pick     = (s0_full & s1_full) ? rr : s1_full;
  assign cur_data = nxt_gnt ? s1_data : s0_data;

  // state register plus the registered FIFO write outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 2'd0;
      gnt   <= 1'b0;
      rr    <= 1'b0;
      en    <= 1'b0;
      din   <= 32'd0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      gnt   <= nxt_gnt;
      en    <= adv;
      if (adv) din <= word;
      if (grant) rr <= ~nxt_gnt;
    end
  end

  // next-state: advance only when the FIFO had room last cycle
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_gnt   = gnt;
    grant     = 1'b0;
    adv       = 1'b0;
    blk_done  = 1'b0;
    eof_done  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.FIFO_tx_full) begin
          if (s0_full | s1_full) begin
            grant     = 1'b1;
            adv       = 1'b1;
            nxt_gnt   = pick;
            nxt_idx   = 2'd0;
            nxt_state = HDR_EN ? HDR : DATA;
          end else if (eof_pend) begin
            adv       = 1'b1;
            nxt_state = EOF;
          end
        end
      end
      HDR: begin
        if (!bus.FIFO_tx_full) begin
          adv       = 1'b1;
          nxt_idx   = 2'd0;
          nxt_state = DATA;
        end
      end
      DATA: begin
        if (idx == 2'd3) begin
          blk_done  = 1'b1;
          nxt_state = IDLE;
        end else if (!bus.FIFO_tx_full) begin
          adv     = 1'b1;
          nxt_idx = idx + 2'd1;
        end
      end
      EOF: begin
        eof_done  = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // output word for the state being entered
  always_comb begin
    word = din;
    case (nxt_state)
      HDR:  word = {8'hA5, nxt_gnt, (nxt_gnt ? 2'b00 : s0_mode), 5'b0, seq16};
      DATA: begin
        case (nxt_idx)
          2'd0:    word = cur_data[127:96];
          2'd1:    word = cur_data[95:64];
          2'd2:    word = cur_data[63:32];
          default: word = cur_data[31:0];
        endcase
      end
      EOF:  word = {8'h5A, 8'h00, seq16};
      default: word = din;
    endcase
  end

  // holding slots: capture when empty, drop and flag when occupied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_full <= 1'b0;
      s1_full <= 1'b0;
      s0_data <= 128'd0;
      s1_data <= 128'd0;
      s0_mode <= 2'd0;
      ovf     <= 1'b0;
    end else begin
      if (blk_done && !gnt) begin
        s0_full <= 1'b0;
      end else if (bus.res_valid && !s0_full) begin
        s0_full <= 1'b1;
        s0_data <= bus.res_data;
        s0_mode <= bus.res_mode;
      end
      if (blk_done && gnt) begin
        s1_full <= 1'b0;
      end else if (bus.q_valid && !s1_full) begin
        s1_full <= 1'b1;
        s1_data <= bus.q_data;
      end
      if ((bus.res_valid && s0_full) || (bus.q_valid && s1_full)) ovf <= 1'b1;
    end
  end

  // sequence/block counters and the pending end-of-frame latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq      <= '0;
      blk_cnt  <= '0;
      eof_pend <= 1'b0;
    end else begin
      if (blk_done) begin
        seq     <= seq + 1'b1;
        blk_cnt <= blk_cnt + 1'b1;
      end
      if (eof_done) eof_pend <= 1'b0;
      else if (bus.frame_done) eof_pend <= 1'b1;
    end
  end

  assign bus.res_busy       = s0_full;
  assign bus.q_busy         = s1_full;
  assign bus.FIFO_tx_din    = din;
  assign bus.FIFO_tx_enable = en;
  assign bus.blk_count      = blk_cnt;
  assign bus.overflow       = ovf;

endmodule

// File: tb/tb_tx_block_arbiter.sv
// Directed bench for tx_block_arbiter: one header-enabled and one header-less instance.
module tb_tx_block_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_block_arbiter_if #(.SEQ_W(16)) ifa ();
  tx_block_arbiter_if #(.SEQ_W(16)) ifb ();

  tx_block_arbiter #(.HDR_EN(1'b1), .SEQ_W(16)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  tx_block_arbiter #(.HDR_EN(1'b0), .SEQ_W(16)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  localparam logic [127:0] D0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D2 = 128'hDEADBEEF_CAFEF00D_13579BDF_2468ACE0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n0;

  logic [31:0] wq_a[$];
  int          cq_a[$];
  logic [31:0] wq_b[$];
  int          cq_b[$];
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // record every FIFO write with the cycle it happened in
  always @(negedge clk) begin
    if (ifa.FIFO_tx_enable === 1'b1) begin
      wq_a.push_back(ifa.FIFO_tx_din);
      cq_a.push_back(cyc);
    end
    if (ifb.FIFO_tx_enable === 1'b1) begin
      wq_b.push_back(ifb.FIFO_tx_din);
      cq_b.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic clear_mon();
    wq_a.delete(); cq_a.delete();
    wq_b.delete(); cq_b.delete();
    exp_q.delete();
  endtask

  function automatic void push_blk(input logic [127:0] d);
    exp_q.push_back(d[127:96]);
    exp_q.push_back(d[95:64]);
    exp_q.push_back(d[63:32]);
    exp_q.push_back(d[31:0]);
  endfunction

  function automatic int cyc_at(input bit use_b, input int i);
    if (use_b) return (i < cq_b.size()) ? cq_b[i] : -1;
    return (i < cq_a.size()) ? cq_a[i] : -1;
  endfunction

  task automatic cmp_words(input string tag, input bit use_b);
    logic [31:0] got;
    check({tag, "_count"}, use_b ? wq_b.size() : wq_a.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (use_b) got = (i < wq_b.size()) ? wq_b[i] : 32'hxxxxxxxx;
      else       got = (i < wq_a.size()) ? wq_a[i] : 32'hxxxxxxxx;
      check($sformatf("%s_w%0d", tag, i), got, exp_q[i]);
    end
  endtask

  initial begin
    ifa.res_data = '0; ifa.res_mode = '0; ifa.res_valid = 1'b0;
    ifa.q_data = '0; ifa.q_valid = 1'b0; ifa.frame_done = 1'b0; ifa.FIFO_tx_full = 1'b0;
    ifb.res_data = '0; ifb.res_mode = '0; ifb.res_valid = 1'b0;
    ifb.q_data = '0; ifb.q_valid = 1'b0; ifb.frame_done = 1'b0; ifb.FIFO_tx_full = 1'b0;

    // reset state
    tick(3);
    check("rst_enable", ifa.FIFO_tx_enable, 1'b0);
    check("rst_din", ifa.FIFO_tx_din, 32'd0);
    check("rst_res_busy", ifa.res_busy, 1'b0);
    check("rst_q_busy", ifa.q_busy, 1'b0);
    check("rst_blk_count", ifa.blk_count, 16'd0);
    check("rst_overflow", ifa.overflow, 1'b0);
    rst = 1'b0;
    tick(1);

    // 1: single residual block, mode 2, seq 0
    clear_mon();
    ifa.res_data = D0; ifa.res_mode = 2'd2; ifa.res_valid = 1'b1;
    n0 = cyc;
    tick();
    ifa.res_valid = 1'b0;
    tick(5);
    @(negedge clk);
    check("t1_busy_n6", ifa.res_busy, 1'b1);
    tick();
    @(negedge clk);
    check("t1_busy_n7", ifa.res_busy, 1'b0);
    exp_q.push_back(32'hA5400000);
    push_blk(D0);
    cmp_words("t1", 1'b0);
    check("t1_hdr_cycle", cyc_at(1'b0, 0), n0 + 2);
    check("t1_last_cycle", cyc_at(1'b0, 4), n0 + 6);
    check("t1_blk_count", ifa.blk_count, 16'd1);

    // 2: simultaneous blocks, twice, after a fresh reset
    do_reset();
    clear_mon();
    for (int p = 0; p < 2; p++) begin
      ifa.res_data = D0; ifa.res_mode = 2'd1; ifa.res_valid = 1'b1;
      ifa.q_data = D1; ifa.q_valid = 1'b1;
      tick();
      ifa.res_valid = 1'b0; ifa.q_valid = 1'b0;
      tick(14);
    end
    exp_q.push_back(32'hA5200000); push_blk(D0);
    exp_q.push_back(32'hA5800001); push_blk(D1);
    exp_q.push_back(32'hA5200002); push_blk(D0);
    exp_q.push_back(32'hA5800003); push_blk(D1);
    cmp_words("t2", 1'b0);
    check("t2_gap", cyc_at(1'b0, 5), cyc_at(1'b0, 4) + 2);
    check("t2_blk_count", ifa.blk_count, 16'd4);

    // 3: FIFO full for 5 cycles after the 2nd data word
    clear_mon();
    ifa.res_data = D2; ifa.res_mode = 2'd3; ifa.res_valid = 1'b1;
    n0 = cyc;
    tick();
    ifa.res_valid = 1'b0;
    tick(3);
    ifa.FIFO_tx_full = 1'b1;
    tick(5);
    ifa.FIFO_tx_full = 1'b0;
    tick(6);
    exp_q.push_back(32'hA5600004); push_blk(D2);
    cmp_words("t3", 1'b0);
    check("t3_d1_cycle", cyc_at(1'b0, 2), n0 + 4);
    check("t3_d2_cycle", cyc_at(1'b0, 3), n0 + 10);
    check("t3_d3_cycle", cyc_at(1'b0, 4), n0 + 11);
    check("t3_blk_count", ifa.blk_count, 16'd5);

    // 4: second q block offered while q slot busy is dropped
    clear_mon();
    ifa.q_data = D1; ifa.q_valid = 1'b1;
    tick();
    ifa.q_valid = 1'b0;
    tick();
    ifa.q_data = D2; ifa.q_valid = 1'b1;
    tick();
    ifa.q_valid = 1'b0;
    check("t4_overflow_set", ifa.overflow, 1'b1);
    tick(12);
    exp_q.push_back(32'hA5800005); push_blk(D1);
    cmp_words("t4", 1'b0);
    check("t4_overflow_sticky", ifa.overflow, 1'b1);
    check("t4_q_busy", ifa.q_busy, 1'b0);
    do_reset();
    check("t4_overflow_cleared", ifa.overflow, 1'b0);

    // 5: frame_done during a pending block, repeated during the drain
    clear_mon();
    ifa.res_data = D0; ifa.res_mode = 2'd0; ifa.res_valid = 1'b1;
    n0 = cyc;
    tick();
    ifa.res_valid = 1'b0; ifa.frame_done = 1'b1;
    tick();
    ifa.frame_done = 1'b0;
    tick(2);
    ifa.frame_done = 1'b1;
    tick();
    ifa.frame_done = 1'b0;
    tick(12);
    exp_q.push_back(32'hA5000000); push_blk(D0);
    exp_q.push_back(32'h5A000001);
    cmp_words("t5", 1'b0);
    check("t5_eof_cycle", cyc_at(1'b0, 5), n0 + 8);
    check("t5_blk_count", ifa.blk_count, 16'd1);

    // 6: reset at the 3rd data word abandons the block
    clear_mon();
    ifa.res_data = D1; ifa.res_mode = 2'd2; ifa.res_valid = 1'b1;
    tick();
    ifa.res_valid = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    check("t6_enable_rst", ifa.FIFO_tx_enable, 1'b0);
    check("t6_busy_rst", ifa.res_busy, 1'b0);
    check("t6_blk_count_rst", ifa.blk_count, 16'd0);
    tick();
    rst = 1'b0;
    tick(6);
    exp_q.push_back(32'hA5400001);
    exp_q.push_back(D1[127:96]);
    exp_q.push_back(D1[95:64]);
    cmp_words("t6", 1'b0);

    // header-less instance: fresh block, exactly four data words
    exp_q.delete();
    ifb.res_data = D2; ifb.res_mode = 2'd1; ifb.res_valid = 1'b1;
    n0 = cyc;
    tick();
    ifb.res_valid = 1'b0;
    tick(8);
    push_blk(D2);
    cmp_words("t6b", 1'b1);
    check("t6b_first_cycle", cyc_at(1'b1, 0), n0 + 2);
    check("t6b_last_cycle", cyc_at(1'b1, 3), n0 + 5);
    check("t6b_blk_count", ifb.blk_count, 16'd1);
    check("t6b_busy", ifb.res_busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
